// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mul_div_unit_pkg;

   localparam int unsigned MduWidthDefault = 32;

   typedef enum logic [1:0] {
      OpMultu = 2'b00,
      OpMult  = 2'b01,
      OpDivu  = 2'b10,
      OpDiv   = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFin
   } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
module mdu_iter_step
   import mul_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = MduWidthDefault
) (
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] opb_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           ge;

   always_comb begin
      sum     = {1'b0, acc_i} + (quo_i[0] ? {1'b0, opb_i} : '0);
      shifted = {acc_i, quo_i[WIDTH-1]};
      diff    = shifted - {1'b0, opb_i};
      ge      = shifted >= {1'b0, opb_i};
      if (is_div_i) begin
         // Partial remainder stays below the divisor, so the low WIDTH bits suffice.
         acc_o = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], ge};
      end else begin
         acc_o = sum[WIDTH:1];
         quo_o = {sum[0], quo_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit with signed fix-up and divide-by-zero shortcut.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = MduWidthDefault
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] busA,
   input  logic [WIDTH-1:0] busB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int unsigned CntW = $clog2(WIDTH);

   mdu_state_e      state_q, state_d;
   mdu_op_e         op_q, op_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sa_q, sa_d, sb_q, sb_d;
   logic            dbz_pend_q, dbz_pend_d;
   logic            dbz_q, dbz_d;
   logic            done_q, done_d;
   logic [WIDTH-1:0] opb_q, opb_d, acc_q, acc_d, quo_q, quo_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

   mdu_op_e          op_in;
   logic             is_div_in, signed_in, sa_in, sb_in, zero_div_in;
   logic             is_div_q, signed_q;
   logic [WIDTH-1:0] mag_a, mag_b, step_acc, step_quo;

   assign op_in       = mdu_op_e'(op);
   assign is_div_in   = (op_in == OpDivu) || (op_in == OpDiv);
   assign signed_in   = (op_in == OpMult) || (op_in == OpDiv);
   assign sa_in       = signed_in & busA[WIDTH-1];
   assign sb_in       = signed_in & busB[WIDTH-1];
   assign mag_a       = sa_in ? -busA : busA;
   assign mag_b       = sb_in ? -busB : busB;
   assign zero_div_in = is_div_in && (busB == '0);
   assign is_div_q    = (op_q == OpDivu) || (op_q == OpDiv);
   assign signed_q    = (op_q == OpMult) || (op_q == OpDiv);

   mdu_iter_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .is_div_i(is_div_q),
      .acc_i   (acc_q),
      .quo_i   (quo_q),
      .opb_i   (opb_q),
      .acc_o   (step_acc),
      .quo_o   (step_quo)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      dbz_pend_d = dbz_pend_q;
      dbz_d      = dbz_q;
      done_d     = 1'b0;
      opb_d      = opb_q;
      acc_d      = acc_q;
      quo_d      = quo_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               op_d       = op_in;
               sa_d       = sa_in;
               sb_d       = sb_in;
               cnt_d      = '0;
               dbz_d      = 1'b0;
               dbz_pend_d = zero_div_in;
               if (zero_div_in) begin
                  acc_d   = busA;
                  quo_d   = '1;
                  state_d = StFin;
               end else begin
                  acc_d   = '0;
                  opb_d   = is_div_in ? mag_b : mag_a;
                  quo_d   = is_div_in ? mag_a : mag_b;
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            acc_d = step_acc;
            quo_d = step_quo;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = StFin;
            end
         end
         StFin: begin
            // First FIN cycle applies the sign fix-up in place; the second publishes it.
            if (cnt_q == '0) begin
               cnt_d = CntW'(1);
               if (!dbz_pend_q && signed_q) begin
                  if (is_div_q) begin
                     if (sa_q ^ sb_q) quo_d = -quo_q;
                     if (sa_q) acc_d = -acc_q;
                  end else if (sa_q ^ sb_q) begin
                     {acc_d, quo_d} = -{acc_q, quo_q};
                  end
               end
            end else begin
               cnt_d   = '0;
               hi_d    = acc_q;
               lo_d    = quo_q;
               done_d  = 1'b1;
               dbz_d   = dbz_pend_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         op_q       <= OpMultu;
         cnt_q      <= '0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         dbz_pend_q <= 1'b0;
         dbz_q      <= 1'b0;
         done_q     <= 1'b0;
         opb_q      <= '0;
         acc_q      <= '0;
         quo_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         dbz_pend_q <= dbz_pend_d;
         dbz_q      <= dbz_d;
         done_q     <= done_d;
         opb_q      <= opb_d;
         acc_q      <= acc_d;
         quo_q      <= quo_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule
